// File: rtl/xgmii_pkg.sv
// XGMII control characters and 64b/66b block-type constants, shared by the
// encoder and decoder.
package xgmii_pkg;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam logic [7:0] BT_IDLE   = 8'h1E;
  localparam logic [7:0] BT_START0 = 8'h78;
  localparam logic [7:0] BT_START4 = 8'h33;
  localparam logic [7:0] BT_TERM0  = 8'h87;
  localparam logic [7:0] BT_TERM1  = 8'h99;
  localparam logic [7:0] BT_TERM2  = 8'hAA;
  localparam logic [7:0] BT_TERM3  = 8'hB4;
  localparam logic [7:0] BT_TERM4  = 8'hCC;
  localparam logic [7:0] BT_TERM5  = 8'hD2;
  localparam logic [7:0] BT_TERM6  = 8'hE1;
  localparam logic [7:0] BT_TERM7  = 8'hFF;

  typedef enum logic {HALF_LOW, HALF_HIGH} half_e;

  // Lane index of the terminate character, or -1 if not a terminate type.
  function automatic int term_index(input logic [7:0] bt);
    case (bt)
      BT_TERM0: return 0;
      BT_TERM1: return 1;
      BT_TERM2: return 2;
      BT_TERM3: return 3;
      BT_TERM4: return 4;
      BT_TERM5: return 5;
      BT_TERM6: return 6;
      BT_TERM7: return 7;
      default:  return -1;
    endcase
  endfunction

endpackage

// File: rtl/xgmii_block_decode.sv
// Combinational 64b/66b block classifier and lane mapper; lane 0 is the
// low byte of o_rxd.
module xgmii_block_decode
  import xgmii_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int HDR_WIDTH  = 2,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
  input  logic [HDR_WIDTH-1:0]    i_sync_hdr,
  input  logic [2*DATA_WIDTH-1:0] i_block,
  output logic [2*DATA_WIDTH-1:0] o_rxd,
  output logic [2*CTRL_WIDTH-1:0] o_rxc,
  output logic                    o_err
);

  localparam int NL = 2 * CTRL_WIDTH;
  localparam int BW = 2 * DATA_WIDTH;

  logic [BW-1:0] payload;
  logic          bad;
  int            term_k;

  // Payload byte i is block byte i+1, i.e. the bytes following the type byte.
  assign payload = i_block >> 8;
  assign term_k  = term_index(i_block[7:0]);

  always_comb begin
    o_rxd = '0;
    o_rxc = '0;
    o_err = 1'b0;
    bad   = 1'b0;
    if (i_sync_hdr == HDR_WIDTH'(SYNC_DATA)) begin
      o_rxd = i_block;
    end else if (i_sync_hdr == HDR_WIDTH'(SYNC_CTRL)) begin
      case (i_block[7:0])
        BT_IDLE: begin
          if (i_block[BW-1:8] == '0) begin
            o_rxd = {NL{XGMII_IDLE}};
            o_rxc = '1;
          end else begin
            bad = 1'b1;
          end
        end
        BT_START0: begin
          o_rxd    = {i_block[BW-1:8], XGMII_START};
          o_rxc[0] = 1'b1;
        end
        BT_START4: begin
          for (int i = 0; i < NL; i++) begin
            if (i < 4) begin
              o_rxd[8*i +: 8] = XGMII_IDLE;
              o_rxc[i]        = 1'b1;
            end else if (i == 4) begin
              o_rxd[8*i +: 8] = XGMII_START;
              o_rxc[i]        = 1'b1;
            end else begin
              o_rxd[8*i +: 8] = i_block[8*i +: 8];
            end
          end
        end
        default: begin
          if (term_k >= 0 && term_k < NL) begin
            for (int i = 0; i < NL; i++) begin
              if (i < term_k) begin
                o_rxd[8*i +: 8] = payload[8*i +: 8];
              end else if (i == term_k) begin
                o_rxd[8*i +: 8] = XGMII_TERM;
                o_rxc[i]        = 1'b1;
              end else begin
                o_rxd[8*i +: 8] = XGMII_IDLE;
                o_rxc[i]        = 1'b1;
              end
            end
          end else begin
            bad = 1'b1;
          end
        end
      endcase
    end else begin
      bad = 1'b1;
    end

    if (bad) begin
      o_rxd = {NL{XGMII_ERROR}};
      o_rxc = '1;
      o_err = 1'b1;
    end
  end

endmodule

// File: rtl/xgmii_decoder.sv
// 64b/66b to XGMII decoder over a half-block (two-beat) datapath: holds the
// low beat, decodes on the high beat, emits low then high XGMII words.
module xgmii_decoder
  import xgmii_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int HDR_WIDTH  = 2,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [HDR_WIDTH-1:0]  i_rx_sync_hdr,
  input  logic                  i_rx_hdr_valid,
  input  logic                  i_rx_data_valid,
  input  logic                  i_rx_block_lock,
  output logic [DATA_WIDTH-1:0] o_xgmii_rxd,
  output logic [CTRL_WIDTH-1:0] o_xgmii_rxc,
  output logic                  o_xgmii_valid,
  output logic                  o_decode_err
);

  localparam int BW = 2 * DATA_WIDTH;
  localparam int CW = 2 * CTRL_WIDTH;

  half_e                 half_q, half_d;
  logic [DATA_WIDTH-1:0] low_data_q, low_data_d;
  logic [HDR_WIDTH-1:0]  low_hdr_q, low_hdr_d;
  logic [DATA_WIDTH-1:0] hi_rxd_q, hi_rxd_d;
  logic [CTRL_WIDTH-1:0] hi_rxc_q, hi_rxc_d;
  logic                  hi_pend_q, hi_pend_d;
  logic [DATA_WIDTH-1:0] rxd_q, rxd_d;
  logic [CTRL_WIDTH-1:0] rxc_q, rxc_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;

  logic [BW-1:0]         dec_rxd;
  logic [CW-1:0]         dec_rxc;
  logic                  dec_err;

  xgmii_block_decode #(
    .DATA_WIDTH (DATA_WIDTH),
    .HDR_WIDTH  (HDR_WIDTH),
    .CTRL_WIDTH (CTRL_WIDTH)
  ) u_block_decode (
    .i_sync_hdr (low_hdr_q),
    .i_block    ({i_rx_data, low_data_q}),
    .o_rxd      (dec_rxd),
    .o_rxc      (dec_rxc),
    .o_err      (dec_err)
  );

  always_comb begin
    half_d     = half_q;
    low_data_d = low_data_q;
    low_hdr_d  = low_hdr_q;
    hi_rxd_d   = hi_rxd_q;
    hi_rxc_d   = hi_rxc_q;
    hi_pend_d  = 1'b0;
    rxd_d      = rxd_q;
    rxc_d      = rxc_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;

    // High beats are at least two cycles apart, so a pending high word never
    // collides with the low word of the next block.
    if (hi_pend_q) begin
      rxd_d   = hi_rxd_q;
      rxc_d   = hi_rxc_q;
      valid_d = 1'b1;
    end

    if (!i_rx_block_lock) begin
      half_d = HALF_LOW;
    end else if (i_rx_data_valid) begin
      if (i_rx_hdr_valid) begin
        err_d      = (half_q == HALF_HIGH);
        low_data_d = i_rx_data;
        low_hdr_d  = i_rx_sync_hdr;
        half_d     = HALF_HIGH;
      end else if (half_q == HALF_LOW) begin
        err_d = 1'b1;
      end else begin
        rxd_d     = dec_rxd[DATA_WIDTH-1:0];
        rxc_d     = dec_rxc[CTRL_WIDTH-1:0];
        valid_d   = 1'b1;
        err_d     = dec_err;
        hi_rxd_d  = dec_rxd[BW-1:DATA_WIDTH];
        hi_rxc_d  = dec_rxc[CW-1:CTRL_WIDTH];
        hi_pend_d = 1'b1;
        half_d    = HALF_LOW;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      half_q     <= HALF_LOW;
      low_data_q <= '0;
      low_hdr_q  <= '0;
      hi_rxd_q   <= '0;
      hi_rxc_q   <= '0;
      hi_pend_q  <= 1'b0;
      rxd_q      <= {CTRL_WIDTH{XGMII_IDLE}};
      rxc_q      <= '1;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      half_q     <= half_d;
      low_data_q <= low_data_d;
      low_hdr_q  <= low_hdr_d;
      hi_rxd_q   <= hi_rxd_d;
      hi_rxc_q   <= hi_rxc_d;
      hi_pend_q  <= hi_pend_d;
      rxd_q      <= rxd_d;
      rxc_q      <= rxc_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign o_xgmii_rxd   = rxd_q;
  assign o_xgmii_rxc   = rxc_q;
  assign o_xgmii_valid = valid_q;
  assign o_decode_err  = err_q;

endmodule

// File: tb/tb_xgmii_decoder.sv
// Directed self-checking bench for xgmii_decoder with hand-computed vectors.
module tb_xgmii_decoder;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_rx_data;
  logic [1:0]  i_rx_sync_hdr;
  logic        i_rx_hdr_valid;
  logic        i_rx_data_valid;
  logic        i_rx_block_lock;
  logic [31:0] o_xgmii_rxd;
  logic [3:0]  o_xgmii_rxc;
  logic        o_xgmii_valid;
  logic        o_decode_err;

  int checks   = 0;
  int failures = 0;

  xgmii_decoder dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_rx_data       (i_rx_data),
    .i_rx_sync_hdr   (i_rx_sync_hdr),
    .i_rx_hdr_valid  (i_rx_hdr_valid),
    .i_rx_data_valid (i_rx_data_valid),
    .i_rx_block_lock (i_rx_block_lock),
    .o_xgmii_rxd     (o_xgmii_rxd),
    .o_xgmii_rxc     (o_xgmii_rxc),
    .o_xgmii_valid   (o_xgmii_valid),
    .o_decode_err    (o_decode_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] d,
                           input logic [3:0] c, input logic e);
    check_val({tag, "_valid"}, 64'(o_xgmii_valid), 64'(v));
    if (v) begin
      check_val({tag, "_rxd"}, 64'(o_xgmii_rxd), 64'(d));
      check_val({tag, "_rxc"}, 64'(o_xgmii_rxc), 64'(c));
    end
    check_val({tag, "_err"}, 64'(o_decode_err), 64'(e));
  endtask

  task automatic sample;
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic [1:0] h, input logic hv, input logic dv);
    @(negedge i_clk);
    i_rx_data       = d;
    i_rx_sync_hdr   = h;
    i_rx_hdr_valid  = hv;
    i_rx_data_valid = dv;
  endtask

  // Low beat, optional idle gap, high beat; then checks both output words.
  task automatic send_block(input string tag, input logic [1:0] h, input logic [31:0] lo,
                            input logic [31:0] hi, input int gap,
                            input logic [31:0] exp_lo, input logic [3:0] exp_lo_c,
                            input logic [31:0] exp_hi, input logic [3:0] exp_hi_c,
                            input logic exp_err);
    drive(lo, h, 1'b1, 1'b1);
    for (int g = 0; g < gap; g++) begin
      drive(32'h0, 2'b00, 1'b0, 1'b0);
      sample();
      check_out({tag, "_gap"}, 1'b0, 32'h0, 4'h0, 1'b0);
    end
    drive(hi, 2'b00, 1'b0, 1'b1);
    sample();
    check_out({tag, "_lo"}, 1'b1, exp_lo, exp_lo_c, exp_err);
    drive(32'h0, 2'b00, 1'b0, 1'b0);
    sample();
    check_out({tag, "_hi"}, 1'b1, exp_hi, exp_hi_c, 1'b0);
    sample();
    check_out({tag, "_after"}, 1'b0, 32'h0, 4'h0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1;
    i_rx_data = '0; i_rx_sync_hdr = '0; i_rx_hdr_valid = 1'b0;
    i_rx_data_valid = 1'b0; i_rx_block_lock = 1'b1;
    repeat (3) sample();
    check_out("reset", 1'b0, 32'h0, 4'h0, 1'b0);
    check_val("reset_rxd", 64'(o_xgmii_rxd), 64'h07070707);
    check_val("reset_rxc", 64'(o_xgmii_rxc), 64'hF);
    @(negedge i_clk); i_reset = 1'b0;
    sample();

    send_block("idle",   2'b10, 32'h0000001E, 32'h00000000, 0, 32'h07070707, 4'hF, 32'h07070707, 4'hF, 1'b0);
    send_block("start0", 2'b10, 32'h33221178, 32'h77665544, 0, 32'h332211FB, 4'h1, 32'h77665544, 4'h0, 1'b0);
    send_block("term4",  2'b10, 32'h221100CC, 32'h00000033, 0, 32'h33221100, 4'h0, 32'h070707FD, 4'hF, 1'b0);
    send_block("hdr11",  2'b11, 32'h33221178, 32'h77665544, 0, 32'hFEFEFEFE, 4'hF, 32'hFEFEFEFE, 4'hF, 1'b1);
    send_block("data",   2'b01, 32'hDDCCBBAA, 32'h44332211, 0, 32'hDDCCBBAA, 4'h0, 32'h44332211, 4'h0, 1'b0);
    send_block("start4", 2'b10, 32'h00000033, 32'h77665500, 0, 32'h07070707, 4'hF, 32'h776655FB, 4'h1, 1'b0);
    send_block("term0",  2'b10, 32'h00000087, 32'h00000000, 0, 32'h070707FD, 4'hF, 32'h07070707, 4'hF, 1'b0);
    send_block("term7",  2'b10, 32'h332211FF, 32'h77665544, 0, 32'h44332211, 4'h0, 32'hFD776655, 4'h8, 1'b0);
    send_block("idlebad",2'b10, 32'h0000011E, 32'h00000000, 0, 32'hFEFEFEFE, 4'hF, 32'hFEFEFEFE, 4'hF, 1'b1);
    send_block("badtype",2'b10, 32'h00000055, 32'h00000000, 0, 32'hFEFEFEFE, 4'hF, 32'hFEFEFEFE, 4'hF, 1'b1);
    send_block("hdr00",  2'b00, 32'h03020100, 32'h07060504, 0, 32'hFEFEFEFE, 4'hF, 32'hFEFEFEFE, 4'hF, 1'b1);
    send_block("gap",    2'b01, 32'h03020100, 32'h07060504, 2, 32'h03020100, 4'h0, 32'h07060504, 4'h0, 1'b0);

    // Back-to-back blocks give a continuous output stream.
    drive(32'h03020100, 2'b01, 1'b1, 1'b1); sample();
    check_out("b2b_0", 1'b0, 32'h0, 4'h0, 1'b0);
    drive(32'h07060504, 2'b00, 1'b0, 1'b1); sample();
    check_out("b2b_1", 1'b1, 32'h03020100, 4'h0, 1'b0);
    drive(32'h33221178, 2'b10, 1'b1, 1'b1); sample();
    check_out("b2b_2", 1'b1, 32'h07060504, 4'h0, 1'b0);
    drive(32'h77665544, 2'b00, 1'b0, 1'b1); sample();
    check_out("b2b_3", 1'b1, 32'h332211FB, 4'h1, 1'b0);
    drive(32'h0, 2'b00, 1'b0, 1'b0); sample();
    check_out("b2b_4", 1'b1, 32'h77665544, 4'h0, 1'b0);
    sample();

    // Header valid again while holding a low half.
    drive(32'hAAAAAAAA, 2'b01, 1'b1, 1'b1); sample();
    check_out("rehdr_0", 1'b0, 32'h0, 4'h0, 1'b0);
    drive(32'h33221178, 2'b10, 1'b1, 1'b1); sample();
    check_out("rehdr_1", 1'b0, 32'h0, 4'h0, 1'b1);
    drive(32'h77665544, 2'b00, 1'b0, 1'b1); sample();
    check_out("rehdr_2", 1'b1, 32'h332211FB, 4'h1, 1'b0);
    drive(32'h0, 2'b00, 1'b0, 1'b0); sample();
    check_out("rehdr_3", 1'b1, 32'h77665544, 4'h0, 1'b0);

    // Beat without header valid while expecting a low half.
    drive(32'h12345678, 2'b01, 1'b0, 1'b1); sample();
    check_out("orphan", 1'b0, 32'h0, 4'h0, 1'b1);
    drive(32'h0, 2'b00, 1'b0, 1'b0); sample();
    check_out("orphan_after", 1'b0, 32'h0, 4'h0, 1'b0);

    // Reset between low and high beats, then reset dropping a pending high word.
    drive(32'h03020100, 2'b01, 1'b1, 1'b1);
    @(negedge i_clk); i_reset = 1'b1; i_rx_data_valid = 1'b0;
    sample();
    check_out("rst_mid", 1'b0, 32'h0, 4'h0, 1'b0);
    check_val("rst_mid_rxd", 64'(o_xgmii_rxd), 64'h07070707);
    check_val("rst_mid_rxc", 64'(o_xgmii_rxc), 64'hF);
    @(negedge i_clk); i_reset = 1'b0;
    drive(32'h07060504, 2'b00, 1'b0, 1'b1); sample();
    check_out("rst_stale_high", 1'b0, 32'h0, 4'h0, 1'b1);
    send_block("post_rst", 2'b10, 32'h221100CC, 32'h00000033, 0, 32'h33221100, 4'h0, 32'h070707FD, 4'hF, 1'b0);
    drive(32'h03020100, 2'b01, 1'b1, 1'b1);
    drive(32'h07060504, 2'b00, 1'b0, 1'b1); sample();
    check_out("rst_pend_lo", 1'b1, 32'h03020100, 4'h0, 1'b0);
    @(negedge i_clk); i_reset = 1'b1; i_rx_data_valid = 1'b0;
    sample();
    check_out("rst_pend_hi", 1'b0, 32'h0, 4'h0, 1'b0);
    check_val("rst_pend_rxd", 64'(o_xgmii_rxd), 64'h07070707);
    @(negedge i_clk); i_reset = 1'b0;

    // Loss of lock discards the held half but not a scheduled high word.
    drive(32'h03020100, 2'b01, 1'b1, 1'b1);
    @(negedge i_clk); i_rx_block_lock = 1'b0; i_rx_data_valid = 1'b0;
    sample();
    check_out("lock_drop", 1'b0, 32'h0, 4'h0, 1'b0);
    @(negedge i_clk); i_rx_block_lock = 1'b1;
    drive(32'h07060504, 2'b00, 1'b0, 1'b1); sample();
    check_out("lock_stale_high", 1'b0, 32'h0, 4'h0, 1'b1);
    drive(32'h03020100, 2'b01, 1'b1, 1'b1);
    drive(32'h07060504, 2'b00, 1'b0, 1'b1); sample();
    check_out("lock_pend_lo", 1'b1, 32'h03020100, 4'h0, 1'b0);
    @(negedge i_clk); i_rx_block_lock = 1'b0; i_rx_data_valid = 1'b0;
    sample();
    check_out("lock_pend_hi", 1'b1, 32'h07060504, 4'h0, 1'b0);
    drive(32'h03020100, 2'b01, 1'b1, 1'b1); sample();
    drive(32'h07060504, 2'b00, 1'b0, 1'b1); sample();
    check_out("nolock_block", 1'b0, 32'h0, 4'h0, 1'b0);
    drive(32'h0, 2'b00, 1'b0, 1'b0); sample();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
